// File: rtl/fpu_share_arb.sv
// Round-robin scheduler sharing one multi-cycle FPU (en/busy/done handshake)
// among NREQ requesters; returns each result as a one-cycle response pulse.
module fpu_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 16,
    parameter int IW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_data,
    output logic              resp_err,
    output logic [IW-1:0]     grant_id,
    output logic              arb_busy,
    output logic              fu_en,
    output logic [W-1:0]      fu_adata,
    output logic [W-1:0]      fu_bdata,
    input  logic [W-1:0]      fu_result,
    input  logic              fu_done,
    input  logic              fu_busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic [W-1:0]      resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic              arb_busy_q, arb_busy_d;
    logic              fu_en_q, fu_en_d;
    logic [W-1:0]      fu_a_q, fu_a_d;
    logic [W-1:0]      fu_b_q, fu_b_d;

    logic              pick_found_s;
    logic [IW-1:0]     pick_idx_s;

    // Round-robin pick: first valid requester after the last grant.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_found_s && req_valid[(int'(last_q) + k) % NREQ]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;
        fu_en_d      = fu_en_q;
        fu_a_d       = fu_a_q;
        fu_b_d       = fu_b_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    fu_a_d      = req_a[int'(pick_idx_s)*W +: W];
                    fu_b_d      = req_b[int'(pick_idx_s)*W +: W];
                    fu_en_d     = 1'b1;
                    req_ready_d = ONE_HOT0 << pick_idx_s;
                    grant_d     = pick_idx_s;
                    last_d      = pick_idx_s;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // The FPU only captures en while it is not busy.
                if (!fu_busy) begin
                    fu_en_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (fu_done) begin
                    resp_data_d  = fu_result;
                    resp_valid_d = ONE_HOT0 << grant_q;
                    state_d      = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = ONE_HOT0 << grant_q;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        arb_busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= IW'(NREQ - 1);
            cnt_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            grant_q      <= '0;
            arb_busy_q   <= 1'b0;
            fu_en_q      <= 1'b0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            grant_q      <= grant_d;
            arb_busy_q   <= arb_busy_d;
            fu_en_q      <= fu_en_d;
            fu_a_q       <= fu_a_d;
            fu_b_q       <= fu_b_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign grant_id   = grant_q;
    assign arb_busy   = arb_busy_q;
    assign fu_en      = fu_en_q;
    assign fu_adata   = fu_a_q;
    assign fu_bdata   = fu_b_q;

endmodule
